// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline controller:
//   - REG_W        : PC / redirect address width, taken from `REG_BUS
//   - STG_*        : stage indices into the stall / flush vectors
//   - STALL_*      : stall vector encodings (each stage also freezes all
//                    stages upstream of it)
//   - FLUSH_*      : flush vector encodings for jump / exception redirects
//   - redir_state_e: pending-redirect FSM encoding
//   - stall_encode : priority encoder from stage requests to stall vector
// ---------------------------------------------------------------------------
`ifndef REG_BUS
`define REG_BUS 32
`endif

package pipe_ctrl_pkg;

    localparam int REG_W = `REG_BUS;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;
    localparam int NUM_STG = STG_WB + 1;

    // A stalling stage holds itself and every stage in front of it.
    localparam logic [NUM_STG-1:0] STALL_NONE = 6'b000000;
    localparam logic [NUM_STG-1:0] STALL_IF   = (6'b000001 << (STG_IF  + 1)) - 6'b000001;
    localparam logic [NUM_STG-1:0] STALL_ID   = (6'b000001 << (STG_ID  + 1)) - 6'b000001;
    localparam logic [NUM_STG-1:0] STALL_EX   = (6'b000001 << (STG_EX  + 1)) - 6'b000001;
    localparam logic [NUM_STG-1:0] STALL_MEM  = (6'b000001 << (STG_MEM + 1)) - 6'b000001;

    localparam logic [NUM_STG-1:0] FLUSH_NONE = 6'b000000;
    localparam logic [NUM_STG-1:0] FLUSH_JUMP = 6'b000001 << STG_IF;
    localparam logic [NUM_STG-1:0] FLUSH_EXCP = (6'b000001 << STG_IF) |
                                                (6'b000001 << STG_ID) |
                                                (6'b000001 << STG_EX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND_J = 2'd1,
        PEND_E = 2'd2
    } redir_state_e;

    // Highest (most downstream) requesting stage decides the stall vector.
    function automatic logic [NUM_STG-1:0] stall_encode(
        input logic if_req,
        input logic id_req,
        input logic ex_req,
        input logic mem_req
    );
        logic [NUM_STG-1:0] vec;
        if (mem_req) begin
            vec = STALL_MEM;
        end else if (ex_req) begin
            vec = STALL_EX;
        end else if (id_req) begin
            vec = STALL_ID;
        end else if (if_req) begin
            vec = STALL_IF;
        end else begin
            vec = STALL_NONE;
        end
        return vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl_redir_buf.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_redir_buf
// Redirect priority mux plus a one-entry pending buffer for redirects that
// arrive while the PC stage is frozen.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   stall_pc            1 = PC stage frozen this cycle
//   jump_req / jump_pc  branch redirect request and target
//   excp_req / excp_pc  exception redirect request and target
//   redir_valid         redirect issued this cycle (combinational)
//   redir_excp          issued redirect is an exception
//   redir_pc            issued target, 0 when no redirect
// Priority: pending entry, then exception, then jump. A buffered jump is
// overwritten by a later exception; a buffered exception is never replaced.
// Requests arriving in the cycle a pending entry is issued are dropped.
// ---------------------------------------------------------------------------
module pipe_ctrl_redir_buf
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W_P = REG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_pc,
    input  logic               jump_req,
    input  logic [REG_W_P-1:0] jump_pc,
    input  logic               excp_req,
    input  logic [REG_W_P-1:0] excp_pc,
    output logic               redir_valid,
    output logic               redir_excp,
    output logic [REG_W_P-1:0] redir_pc
);

    redir_state_e       state_r;
    redir_state_e       state_next_s;
    logic [REG_W_P-1:0] pend_pc_r;
    logic [REG_W_P-1:0] pend_pc_next_s;

    // State and pending-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pend_pc_r <= {REG_W_P{1'b0}};
        end else begin
            state_r   <= state_next_s;
            pend_pc_r <= pend_pc_next_s;
        end
    end

    // Next-state, buffer update and zero-latency redirect issue.
    always_comb begin
        state_next_s   = state_r;
        pend_pc_next_s = pend_pc_r;
        redir_valid    = 1'b0;
        redir_excp     = 1'b0;
        redir_pc       = {REG_W_P{1'b0}};
        case (state_r)
            IDLE: begin
                if (excp_req) begin
                    if (stall_pc) begin
                        state_next_s   = PEND_E;
                        pend_pc_next_s = excp_pc;
                    end else begin
                        redir_valid = 1'b1;
                        redir_excp  = 1'b1;
                        redir_pc    = excp_pc;
                    end
                end else if (jump_req) begin
                    if (stall_pc) begin
                        state_next_s   = PEND_J;
                        pend_pc_next_s = jump_pc;
                    end else begin
                        redir_valid = 1'b1;
                        redir_pc    = jump_pc;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            PEND_J: begin
                if (!stall_pc) begin
                    redir_valid    = 1'b1;
                    redir_pc       = pend_pc_r;
                    state_next_s   = IDLE;
                    pend_pc_next_s = {REG_W_P{1'b0}};
                end else if (excp_req) begin
                    // Exception supersedes the buffered branch.
                    state_next_s   = PEND_E;
                    pend_pc_next_s = excp_pc;
                end else begin
                    state_next_s = PEND_J;
                end
            end
            PEND_E: begin
                if (!stall_pc) begin
                    redir_valid    = 1'b1;
                    redir_excp     = 1'b1;
                    redir_pc       = pend_pc_r;
                    state_next_s   = IDLE;
                    pend_pc_next_s = {REG_W_P{1'b0}};
                end else begin
                    state_next_s = PEND_E;
                end
            end
            default: begin
                state_next_s   = IDLE;
                pend_pc_next_s = {REG_W_P{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline controller: stall vector generation, redirect arbitration
// toward the fetch unit (via pipe_ctrl_redir_buf), flush pulses and a sticky
// stall watchdog.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if/id/ex/mem_stall_req_i        per-stage stall requests
//   jump_req_i, jump_pc_i           branch redirect from decode
//   excp_req_i, excp_pc_i           trap / interrupt / mret redirect
//   stall_o[5:0]                    [0]pc [1]if [2]id [3]ex [4]mem [5]wb hold
//   flush_o[5:0]                    same indexing, clear pipeline register
//   redirect_req_o/excp_o/pc_o      redirect toward fetch (same cycle)
//   stall_timeout_o                 sticky: STALL_TIMEOUT consecutive stalls
// Optional build macro PIPE_CTRL_PERF_EN adds:
//   stall_cycles_o[31:0]            cycles with stall_o[0]=1, wrapping
//   redirect_cnt_o[15:0]            accepted redirects, wrapping
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W_P       = REG_W,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_stall_req_i,
    input  logic               id_stall_req_i,
    input  logic               ex_stall_req_i,
    input  logic               mem_stall_req_i,
    input  logic               jump_req_i,
    input  logic [REG_W_P-1:0] jump_pc_i,
    input  logic               excp_req_i,
    input  logic [REG_W_P-1:0] excp_pc_i,
    output logic [5:0]         stall_o,
    output logic [5:0]         flush_o,
    output logic               redirect_req_o,
    output logic               redirect_excp_o,
    output logic [REG_W_P-1:0] redirect_pc_o,
    output logic               stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cycles_o,
    output logic [15:0]        redirect_cnt_o
`endif
);

    logic [5:0]       stall_raw_s;
    logic [5:0]       flush_s;
    logic             redir_valid_s;
    logic             redir_excp_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] stall_cnt_next_s;
    logic             timeout_r;

    // Stall vector from stage requests.
    always_comb begin
        stall_raw_s = stall_encode(if_stall_req_i, id_stall_req_i,
                                   ex_stall_req_i, mem_stall_req_i);
    end

    pipe_ctrl_redir_buf #(
        .REG_W_P (REG_W_P)
    ) u_redir_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_pc    (stall_raw_s[STG_PC]),
        .jump_req    (jump_req_i),
        .jump_pc     (jump_pc_i),
        .excp_req    (excp_req_i),
        .excp_pc     (excp_pc_i),
        .redir_valid (redir_valid_s),
        .redir_excp  (redir_excp_s),
        .redir_pc    (redirect_pc_o)
    );

    // Flush pulse accompanies an accepted redirect; flush wins over stall.
    always_comb begin
        if (redir_valid_s) begin
            flush_s = redir_excp_s ? FLUSH_EXCP : FLUSH_JUMP;
        end else begin
            flush_s = FLUSH_NONE;
        end
        stall_o         = stall_raw_s & ~flush_s;
        flush_o         = flush_s;
        redirect_req_o  = redir_valid_s;
        redirect_excp_o = redir_excp_s;
    end

    // Watchdog counter next value: saturating count of consecutive stalls.
    always_comb begin
        if (stall_raw_s == STALL_NONE) begin
            stall_cnt_next_s = {CNT_W{1'b0}};
        end else if (stall_cnt_r == {CNT_W{1'b1}}) begin
            stall_cnt_next_s = stall_cnt_r;
        end else begin
            stall_cnt_next_s = stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            timeout_r   <= 1'b0;
        end else begin
            stall_cnt_r <= stall_cnt_next_s;
            timeout_r   <= timeout_r | (stall_cnt_next_s >= CNT_W'(STALL_TIMEOUT));
        end
    end

    assign stall_timeout_o = timeout_r;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_r;
    logic [15:0] redirect_cnt_r;

    // Free-running performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= 32'd0;
            redirect_cnt_r <= 16'd0;
        end else begin
            if (stall_raw_s[STG_PC]) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (redir_valid_s) begin
                redirect_cnt_r <= redirect_cnt_r + 16'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_r;
    assign redirect_cnt_o = redirect_cnt_r;
`endif

endmodule
